// File: rtl/esc_pkg.sv
// Shared constants and pulse-width helper for the multi-channel ESC driver.
// Widths are in clock cycles.
package esc_pkg;

   localparam int ESC_MIN_PULSE = 6250;
   localparam int ESC_SCALE     = 3;
   localparam int ESC_MAX_PULSE = 12000;

   // Full 32-bit arithmetic so the sum can never wrap before the clamp.
   function automatic int esc_width(
      input int spd,
      input int min_p,
      input int scale,
      input int max_p
   );
      int raw;
      raw = min_p + scale * spd;
      return (raw > max_p) ? max_p : raw;
   endfunction

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output: a load sets PWM high for exactly `width` cycles.
// A load while high restarts the count without a low glitch.
module esc_pwm_channel #(
   parameter int CNT_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] width,
   output logic             pwm
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         pwm <= 1'b0;
      end else if (load) begin
         cnt <= width - CNT_W'(1);
         pwm <= 1'b1;
      end else if (pwm) begin
         if (cnt == '0) begin
            pwm <= 1'b0;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/esc_interface_mc.sv
// Multi-channel ESC pulse generator: input pipeline, shadow speeds,
// trigger source (per-write or frame tick), arm gating and status.
module esc_interface_mc
   import esc_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int SPEED_W      = 11,
   parameter int SCALE        = ESC_SCALE,
   parameter int MIN_PULSE    = ESC_MIN_PULSE,
   parameter int MAX_PULSE    = ESC_MAX_PULSE,
   parameter int FRAME_CYCLES = 0,
   parameter int CNT_W        = $clog2(MAX_PULSE + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wrt,
   input  logic [NUM_CH*SPEED_W-1:0] SPEED,
   input  logic                      arm,
   output logic [NUM_CH-1:0]         PWM,
   output logic                      busy,
   output logic                      frame_start
);

   logic                      wrt_q;
   logic [NUM_CH*SPEED_W-1:0] speed_q;
   logic [NUM_CH*SPEED_W-1:0] shadow;
   logic                      trig;

   always_ff @(posedge clk) begin
      if (rst) begin
         wrt_q       <= 1'b0;
         speed_q     <= '0;
         shadow      <= '0;
         frame_start <= 1'b0;
      end else begin
         wrt_q       <= wrt;
         speed_q     <= SPEED;
         frame_start <= trig;
         if (wrt_q) begin
            shadow <= speed_q;
         end
      end
   end

   generate
      if (FRAME_CYCLES == 0) begin : g_legacy
         assign trig = wrt_q;
      end else begin : g_auto
         localparam int FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
         logic [FC_W-1:0] frame_cnt;

         // Cleared by reset so the first tick lands on the first free edge.
         always_ff @(posedge clk) begin
            if (rst) begin
               frame_cnt <= '0;
            end else if (frame_cnt == FC_W'(FRAME_CYCLES - 1)) begin
               frame_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end

         assign trig = (frame_cnt == '0);
      end
   endgenerate

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SPEED_W-1:0] eff;
      logic [CNT_W-1:0]   width;

      // A write landing on the trigger edge bypasses the shadow copy.
      assign eff = wrt_q ? speed_q[i*SPEED_W +: SPEED_W]
                         : shadow[i*SPEED_W +: SPEED_W];

      assign width = arm
         ? CNT_W'(esc_width(32'(eff), MIN_PULSE, SCALE, MAX_PULSE))
         : CNT_W'(MIN_PULSE);

      esc_pwm_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .load (trig),
         .width(width),
         .pwm  (PWM[i])
      );
   end

   assign busy = |PWM;

endmodule
